// File: rtl/sample_ser_pkg.sv
// Shared types and constants for the sample serializer.
// Define SAMPLE_SER_PARITY_EN to append an even-parity bit to each frame.
package sample_ser_pkg;

    localparam int DEF_DATA_W = 12;

`ifdef SAMPLE_SER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

    localparam int FRAME_BITS = frame_bits(DEF_DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } ser_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; a push while full is accepted only alongside a pop.
module sample_fifo #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               wdata,
    input  logic                            push,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rdata,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/sample_serializer.sv
// Buffers decimated samples and ships them MSB-first on a 3-wire serial link.
// Define SAMPLE_SER_PARITY_EN to append an even-parity bit to each frame.
module sample_serializer
    import sample_ser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            new_data,
    output logic                            ser_clk,
    output logic                            ser_data,
    output logic                            ser_frame,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int FB    = frame_bits(DATA_W);
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int CNT_W = $clog2(FB + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FB - 1);

    ser_state_t        state;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  bit_cnt;
    logic [FB-1:0]     shreg;
    logic [FB-1:0]     frame_word;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wdata (data_in),
        .push  (new_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef SAMPLE_SER_PARITY_EN
    assign frame_word = {head, ^head};
`else
    assign frame_word = head;
`endif

    assign pop = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_frame <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (new_data && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= frame_word;
                        ser_data  <= frame_word[FB-1];
                        ser_frame <= 1'b1;
                        ser_clk   <= 1'b0;
                        div       <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        // bit boundary: clock falls, data advances
                        div     <= '0;
                        ser_clk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            ser_frame <= 1'b0;
                            ser_data  <= 1'b0;
                            state     <= GAP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= shreg << 1;
                            ser_data <= shreg[FB-2];
                        end
                    end else begin
                        div <= div + 1'b1;
                        if (div == DIV_HALF) begin
                            ser_clk <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Consumes the decimated 12-bit sample stream (one `data` word qualified by a one-cycle `new_data` strobe) and transmits each sample off-chip over a three-wire synchronous serial link (`ser_clk`, `ser_data`, `ser_frame`). It sits directly downstream of the decimator in `digital_top`. A small FIFO absorbs strobes that arrive while a frame is in flight.

## Interface
- `DATA_W`, 12, sample width in bits.
- `FIFO_DEPTH`, 4, sample buffer entries; power of two, at least 2.
- `CLK_DIV`, 4, `clk` cycles per `ser_clk` half-period; at least 1.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  DATA_W  sample, unsigned; valid only when `new_data`=1.
- `new_data`  in  1  one-cycle write strobe.
- `ser_clk`  out  1  serial clock, idle low.
- `ser_data`  out  1  serial data, MSB first, idle low.
- `ser_frame`  out  1  high for the full duration of a frame.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset** (`rst_n`=0 at an edge):
  - Outputs: `ser_clk`=0, `ser_data`=0, `ser_frame`=0, `overflow`=0, `fifo_level`=0.
  - FIFO emptied, FSM returns to IDLE, divider cleared.
  - `new_data` is ignored during reset.
  - Reset mid-frame aborts the frame immediately; no partial completion.
- **Write:**
  - A `new_data`=1 edge with the FIFO not full pushes `data_in`.
  - A push while full is dropped and sets `overflow`.
  - Push and pop on the same edge while full: the push is accepted and `fifo_level` is unchanged.
- **Frame length:** FRAME_BITS = DATA_W, or DATA_W+1 with parity (see Configuration).
- **FSM:**
  - IDLE: if FIFO not empty, pop the head into the shift register, set `ser_frame`=1, drive `ser_data`=MSB, clear divider, go to SHIFT.
  - SHIFT: each bit lasts 2·CLK_DIV cycles.
    - `ser_clk`=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV.
    - `ser_data` changes only on the edge where `ser_clk` returns 0.
    - After the last bit's high phase: `ser_frame`=0, `ser_clk`=0, `ser_data`=0, go to GAP.
  - GAP: hold idle levels for 2·CLK_DIV cycles, then go to IDLE.
- **Receiver contract:** sample `ser_data` on rising `ser_clk`; `ser_data` is stable for CLK_DIV cycles on either side of that edge.
- **Throughput:** with defaults, a frame plus gap is 104 cycles, well under the 512-cycle sample interval; overflow indicates misconfiguration.

## Timing
- Strobe sampled at edge E into an empty FIFO with FSM in IDLE:
  - `fifo_level`=1 after E.
  - `ser_frame` rises and the MSB is driven after E+1; `fifo_level` returns to 0 after E+1.
- First rising `ser_clk` after E+1+CLK_DIV.
- Frame occupies exactly FRAME_BITS·2·CLK_DIV cycles of `ser_frame`=1.
- Minimum frame-to-frame spacing (falling to rising `ser_frame`): 2·CLK_DIV+1 cycles.
- `overflow` is visible the cycle after the dropped strobe edge.
- All outputs are registered.

## Configuration
- `SAMPLE_SER_PARITY_EN` defined:
  - One extra bit after the LSB: the even parity of the sample (XOR of all DATA_W bits).
  - FRAME_BITS = DATA_W+1.
- Not defined: FRAME_BITS = DATA_W, no parity logic.

## Structure
- Package `sample_ser_pkg`:
  - default DATA_W;
  - FSM state enum (IDLE, SHIFT, GAP);
  - FRAME_BITS constant derived under the macro.
- Sub-module `sample_fifo`:
  - synchronous FIFO, parameters DATA_W and FIFO_DEPTH;
  - ports: push, pop, full, empty, level;
  - implements the full-with-simultaneous-pop rule.
- FSM, divider and shift register live in the top.

## Test plan
- **Single sample:** `CLK_DIV`=2, push 0xA5C.
  - `ser_frame` high 48 cycles.
  - Bits sampled on rising `ser_clk` = 1010_0101_1100.
  - `fifo_level` 0→1→0.
- **Burst:** push 4 strobes on consecutive cycles (0x001, 0x002, 0x004, 0x008).
  - `fifo_level` peaks at 4 (minus 1 for the concurrent pop).
  - Four frames in order, each separated by ≥2·CLK_DIV idle cycles.
  - `overflow`=0.
- **Overflow:** 6 back-to-back strobes with `FIFO_DEPTH`=4.
  - Exactly one sample lost (the sixth); `overflow`=1 from the cycle after and held.
  - Five frames emitted.
- **Reset mid-frame:** assert `rst_n`=0 for one edge during bit 5 of 0xFFF.
  - Next cycle all outputs 0 and `fifo_level`=0.
  - No further `ser_clk` edges until a new strobe.
- **Parity** (`SAMPLE_SER_PARITY_EN`): push 0x007, then 0x003.
  - 13-bit frames; trailing bit 1, then 0.
- **Strobe during reset:** `new_data`=1 while `rst_n`=0.
  - No frame and `fifo_level`=0 after release.
